// File: rtl/icmp_pkg.sv
// Shared constants for the ICMP echo-reply scheduler: FSM state encoding and
// ICMP message type codes.
package icmp_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_SEND = 2'd2;
   localparam logic [1:0] ST_GAP  = 2'd3;

   localparam logic [7:0] ICMP_TYPE_ECHO_REQ   = 8'd8;
   localparam logic [7:0] ICMP_TYPE_ECHO_REPLY = 8'd0;

endpackage

// File: rtl/icmp_seq_fifo.sv
// First-word-fall-through FIFO of pending echo sequence numbers.
// The caller must not push when full (unless also popping) or pop when empty.
module icmp_seq_fifo #(
   parameter int P_DEPTH = 4,
   parameter int P_WIDTH = 16
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_push,
   input  logic [P_WIDTH-1:0]         i_data,
   input  logic                       i_pop,
   output logic [P_WIDTH-1:0]         o_data,
   output logic                       o_empty,
   output logic                       o_full,
   output logic [$clog2(P_DEPTH):0]  o_count
);

   localparam int AW = $clog2(P_DEPTH);

   logic [P_WIDTH-1:0] mem [P_DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [AW:0]        count;

   // Storage needs no reset; only the pointers and occupancy define validity.
   always_ff @(posedge i_clk) begin
      if (i_push) mem[wr_ptr] <= i_data;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (i_push) wr_ptr <= wr_ptr + 1'b1;
         if (i_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({i_push, i_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign o_data  = mem[rd_ptr];
   assign o_empty = (count == '0);
   assign o_full  = (count == (AW+1)'(P_DEPTH));
   assign o_count = count;

endmodule

// File: rtl/icmp_reply_sched.sv
// Queues received echo-request sequence numbers and hands them one at a time
// to the ICMP TX path. Optional inter-reply gap: define ICMP_RATE_LIMIT_EN.
module icmp_reply_sched
   import icmp_pkg::*;
#(
   parameter int P_FIFO_DEPTH = 4,
   parameter int P_TIMEOUT    = 4096,
   parameter int P_RATE_GAP   = 1024
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_trig_reply,
   input  logic [15:0] i_trig_seq,
   output logic        o_icmp_req,
   output logic [15:0] o_icmp_seq,
   input  logic        i_icmp_grant,
   input  logic        i_icmp_done,
   output logic        o_busy,
   output logic [4:0]  o_pending,
   output logic [15:0] o_drop_cnt
);

   localparam int TW = $clog2(P_TIMEOUT + 1);
   localparam int CW = $clog2(P_FIFO_DEPTH) + 1;

   if (P_FIFO_DEPTH < 2 || P_FIFO_DEPTH > 16 || (P_FIFO_DEPTH & (P_FIFO_DEPTH - 1)) != 0
       || P_TIMEOUT < 1 || P_RATE_GAP < 1) begin : g_bad_param
      $error("icmp_reply_sched: illegal parameter value");
   end

   logic [1:0]    state;
   logic [TW-1:0] send_cnt;
   logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [15:0]   fifo_head;
   logic [CW-1:0] fifo_cnt;
   logic          drop_trig, abort;
   logic [1:0]    drop_inc;
   logic [16:0]   drop_sum;

   // A full FIFO still accepts a trigger when the head leaves in the same cycle.
   assign fifo_pop  = (state == ST_REQ) && i_icmp_grant;
   assign fifo_push = i_trig_reply && (!fifo_full || fifo_pop);
   assign drop_trig = i_trig_reply && fifo_full && !fifo_pop;
   assign abort     = (state == ST_SEND) && !i_icmp_done && (send_cnt == TW'(P_TIMEOUT - 1));

   icmp_seq_fifo #(.P_DEPTH(P_FIFO_DEPTH), .P_WIDTH(16)) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (fifo_push),
      .i_data  (i_trig_seq),
      .i_pop   (fifo_pop),
      .o_data  (fifo_head),
      .o_empty (fifo_empty),
      .o_full  (fifo_full),
      .o_count (fifo_cnt)
   );

`ifdef ICMP_RATE_LIMIT_EN
   localparam int GW = $clog2(P_RATE_GAP + 1);
   logic [GW-1:0] gap_cnt;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= ST_IDLE;
         o_icmp_req <= 1'b0;
         o_icmp_seq <= '0;
         send_cnt   <= '0;
`ifdef ICMP_RATE_LIMIT_EN
         gap_cnt    <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: if (!fifo_empty) begin
               o_icmp_seq <= fifo_head;
               o_icmp_req <= 1'b1;
               state      <= ST_REQ;
            end
            ST_REQ: if (i_icmp_grant) begin
               o_icmp_req <= 1'b0;
               send_cnt   <= '0;
               state      <= ST_SEND;
            end
            ST_SEND: begin
               if (i_icmp_done) begin
`ifdef ICMP_RATE_LIMIT_EN
                  gap_cnt <= '0;
                  state   <= ST_GAP;
`else
                  state   <= ST_IDLE;
`endif
               end else if (abort) begin
                  state <= ST_IDLE;
               end else begin
                  send_cnt <= send_cnt + 1'b1;
               end
            end
`ifdef ICMP_RATE_LIMIT_EN
            ST_GAP: begin
               if (gap_cnt == GW'(P_RATE_GAP - 1)) state <= ST_IDLE;
               else gap_cnt <= gap_cnt + 1'b1;
            end
`endif
            default: begin
               state      <= ST_IDLE;
               o_icmp_req <= 1'b0;
            end
         endcase
      end
   end

   // A trigger drop and a send abort can coincide; both are counted.
   assign drop_inc = {1'b0, drop_trig} + {1'b0, abort};
   assign drop_sum = {1'b0, o_drop_cnt} + 17'(drop_inc);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) o_drop_cnt <= '0;
      else          o_drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end

   assign o_busy    = (state != ST_IDLE);
   assign o_pending = 5'(fifo_cnt);

endmodule

// File: tb/tb_icmp_reply_sched.sv
// Directed self-checking bench for icmp_reply_sched (rate-gap check only
// when ICMP_RATE_LIMIT_EN is defined).
module tb_icmp_reply_sched;

   localparam int GAP = 16;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_trig_reply;
   logic [15:0] i_trig_seq;
   logic        o_icmp_req;
   logic [15:0] o_icmp_seq;
   logic        i_icmp_grant;
   logic        i_icmp_done;
   logic        o_busy;
   logic [4:0]  o_pending;
   logic [15:0] o_drop_cnt;

   int checks   = 0;
   int failures = 0;

   icmp_reply_sched #(.P_FIFO_DEPTH(4), .P_TIMEOUT(4096), .P_RATE_GAP(GAP)) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_trig_reply (i_trig_reply),
      .i_trig_seq   (i_trig_seq),
      .o_icmp_req   (o_icmp_req),
      .o_icmp_seq   (o_icmp_seq),
      .i_icmp_grant (i_icmp_grant),
      .i_icmp_done  (i_icmp_done),
      .o_busy       (o_busy),
      .o_pending    (o_pending),
      .o_drop_cnt   (o_drop_cnt)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Done pulse, then wait out the optional gap so the FSM is back in IDLE.
   task automatic finish_done();
      i_icmp_done = 1'b1;
      tick();
      i_icmp_done = 1'b0;
`ifdef ICMP_RATE_LIMIT_EN
      repeat (GAP) tick();
`endif
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] order [5];
      int          n;
      order = '{16'h1, 16'h2, 16'h3, 16'h4, 16'h6};

      i_rst_n = 1'b0; i_trig_reply = 1'b0; i_trig_seq = '0;
      i_icmp_grant = 1'b0; i_icmp_done = 1'b0;
      tick(); tick();
      chk("rst_req", o_icmp_req, 0);
      chk("rst_seq", o_icmp_seq, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_pending", o_pending, 0);
      chk("rst_drop", o_drop_cnt, 0);
      i_rst_n = 1'b1;
      tick();

      // single trigger: request rises two edges after the pulse
      i_trig_reply = 1'b1; i_trig_seq = 16'h0001;
      tick();
      i_trig_reply = 1'b0;
      chk("single_req_early", o_icmp_req, 0);
      chk("single_pending", o_pending, 1);
      tick();
      chk("single_req", o_icmp_req, 1);
      chk("single_seq", o_icmp_seq, 16'h0001);
      i_icmp_grant = 1'b1;
      tick();
      i_icmp_grant = 1'b0;
      chk("single_req_drop", o_icmp_req, 0);
      chk("single_send_busy", o_busy, 1);
      chk("single_popped", o_pending, 0);
      finish_done();
      chk("single_idle", o_busy, 0);
      chk("single_pending_end", o_pending, 0);

      // five back-to-back triggers into depth 4, no grant
      for (int i = 1; i <= 5; i++) begin
         i_trig_reply = 1'b1; i_trig_seq = 16'(i);
         tick();
      end
      i_trig_reply = 1'b0;
      chk("burst_pending", o_pending, 4);
      chk("burst_drop", o_drop_cnt, 1);

      // serve in order; first grant coincides with a trigger into the full FIFO
      for (int k = 0; k < 5; k++) begin
         chk("order_req", o_icmp_req, 1);
         chk("order_seq", o_icmp_seq, order[k]);
         i_icmp_grant = 1'b1;
         if (k == 0) begin i_trig_reply = 1'b1; i_trig_seq = 16'h0006; end
         tick();
         i_icmp_grant = 1'b0; i_trig_reply = 1'b0;
         if (k == 0) begin
            chk("full_pushpop_pending", o_pending, 4);
            chk("full_pushpop_drop", o_drop_cnt, 1);
         end
         chk("order_req_low", o_icmp_req, 0);
         finish_done();
         chk("order_idle", o_busy, 0);
         tick();
      end
      chk("order_empty", o_pending, 0);
      chk("order_no_req", o_icmp_req, 0);

      // send timeout
      i_trig_reply = 1'b1; i_trig_seq = 16'h00A0;
      tick();
      i_trig_seq = 16'h00A1;
      tick();
      i_trig_reply = 1'b0;
      chk("to_req", o_icmp_req, 1);
      chk("to_seq", o_icmp_seq, 16'h00A0);
      i_icmp_grant = 1'b1;
      tick();
      i_icmp_grant = 1'b0;
      repeat (4095) tick();
      chk("to_still_send", o_busy, 1);
      chk("to_drop_before", o_drop_cnt, 1);
      tick();
      chk("to_drop_after", o_drop_cnt, 2);
      chk("to_idle", o_busy, 0);
      tick();
      chk("to_next_req", o_icmp_req, 1);
      chk("to_next_seq", o_icmp_seq, 16'h00A1);
      i_icmp_grant = 1'b1;
      tick();
      i_icmp_grant = 1'b0;
      finish_done();
      chk("to_done_idle", o_busy, 0);

      // asynchronous reset while in SEND
      i_trig_reply = 1'b1; i_trig_seq = 16'h0055;
      tick();
      i_trig_reply = 1'b0;
      tick();
      i_icmp_grant = 1'b1;
      tick();
      i_icmp_grant = 1'b0;
      chk("ar_in_send", o_busy, 1);
      #2 i_rst_n = 1'b0;
      #1;
      chk("ar_req", o_icmp_req, 0);
      chk("ar_seq", o_icmp_seq, 0);
      chk("ar_busy", o_busy, 0);
      chk("ar_pending", o_pending, 0);
      chk("ar_drop", o_drop_cnt, 0);
      #1 i_rst_n = 1'b1;
      tick();
      i_trig_reply = 1'b1; i_trig_seq = 16'h0077;
      tick();
      i_trig_reply = 1'b0;
      tick();
      chk("ar_new_req", o_icmp_req, 1);
      chk("ar_new_seq", o_icmp_seq, 16'h0077);
      i_icmp_grant = 1'b1;
      tick();
      i_icmp_grant = 1'b0;
      finish_done();
      chk("ar_new_idle", o_busy, 0);
      chk("ar_new_drop", o_drop_cnt, 0);

`ifdef ICMP_RATE_LIMIT_EN
      i_trig_reply = 1'b1; i_trig_seq = 16'h0010;
      tick();
      i_trig_seq = 16'h0011;
      tick();
      i_trig_reply = 1'b0;
      i_icmp_grant = 1'b1;
      tick();
      i_icmp_grant = 1'b0;
      i_icmp_done = 1'b1;
      tick();
      i_icmp_done = 1'b0;
      n = 0;
      while (!o_icmp_req && n < 100) begin
         tick();
         n++;
      end
      chk("gap_req_seen", o_icmp_req, 1);
      chk("gap_min_cycles", (n >= GAP + 1) ? 1 : 0, 1);
      chk("gap_seq", o_icmp_seq, 16'h0011);
`else
      n = 0;
      chk("cfg_nogap_pending", o_pending + 5'(n), 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/icmp_reply_sched.md
ICMP_REPLY_SCHED -- requirements
Module: icmp_reply_sched

Interface
REQ-001 SHALL have parameter P_FIFO_DEPTH, default 4, meaning the number of pending echo-reply sequence numbers held (power of 2, 2..16).
REQ-002 SHALL have parameter P_TIMEOUT, default 4096, meaning the max cycles in SEND without i_icmp_done before abort.
REQ-003 SHALL have parameter P_RATE_GAP, default 1024, meaning the min idle cycles between replies (used only with ICMP_RATE_LIMIT_EN).
REQ-004 SHALL have port i_clk  input  1  system clock; all logic is on its rising edge.
REQ-005 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_trig_reply  input  1  single-cycle pulse: an echo request was received.
REQ-007 SHALL have port i_trig_seq  input  16  sequence number, valid with i_trig_reply.
REQ-008 SHALL have port o_icmp_req  output  1  request to the ICMP TX path.
REQ-009 SHALL have port o_icmp_seq  output  16  sequence number for the reply, stable while o_icmp_req=1 and in SEND.
REQ-010 SHALL have port i_icmp_grant  input  1  TX path accepts the request (sampled only in REQ).
REQ-011 SHALL have port i_icmp_done  input  1  pulse: reply frame fully transmitted (sampled only in SEND).
REQ-012 SHALL have port o_busy  output  1  FSM not in IDLE.
REQ-013 SHALL have port o_pending  output  5  FIFO occupancy, 0..P_FIFO_DEPTH.
REQ-014 SHALL have port o_drop_cnt  output  16  triggers discarded (FIFO full) plus aborted sends, saturating.

Function
REQ-015 SHALL push i_trig_seq into the FIFO on each cycle where i_trig_reply=1 and the FIFO is not full; occupancy updates at the next edge.
REQ-016 SHALL discard a trigger arriving when full and no pop occurs that cycle, incrementing o_drop_cnt by 1.
REQ-017 SHALL accept both push and pop in the same cycle when full; occupancy is unchanged.
REQ-018 SHALL implement the FSM IDLE->REQ->SEND->(GAP)->IDLE.
REQ-019 In IDLE with the FIFO non-empty, the FSM SHALL load o_icmp_seq from the FIFO head and move to REQ.
REQ-020 SHALL make o_icmp_req registered and 1 exactly while in REQ; with the FIFO empty and the FSM idle, o_icmp_req rises 2 cycles after the i_trig_reply pulse.
REQ-021 In REQ with i_icmp_grant=1, the FSM SHALL pop the FIFO head and move to SEND; o_icmp_req is 0 the following cycle.
REQ-022 SHALL hold REQ indefinitely without grant; no timeout applies in REQ.
REQ-023 In SEND with i_icmp_done=1, the FSM SHALL go to GAP when the macro is defined, else to IDLE.
REQ-024 In SEND, the FSM SHALL count cycles; on reaching P_TIMEOUT without done it returns to IDLE and increments o_drop_cnt.
REQ-025 SHALL ignore i_icmp_grant outside REQ and i_icmp_done outside SEND.
REQ-026 SHALL saturate o_drop_cnt at 16'hFFFF; a simultaneous drop and abort adds 2 (saturating).
REQ-027 SHALL serve replies strictly in FIFO order with no reordering or merging of equal sequence numbers.

Reset
REQ-028 On i_rst_n=0, SHALL immediately reset: FSM=IDLE, FIFO empty, o_icmp_req=0, o_icmp_seq=0, o_busy=0, o_pending=0, o_drop_cnt=0, counters=0.
REQ-029 SHALL abandon a reply interrupted by reset mid-REQ/SEND; it is not counted as dropped.

Configuration
REQ-030 With macro ICMP_RATE_LIMIT_EN defined, SHALL enter GAP after done and stay P_RATE_GAP cycles before IDLE, while triggers are still queued during GAP.
REQ-031 Without ICMP_RATE_LIMIT_EN, SHALL not build the GAP state or its counter, and P_RATE_GAP has no effect.

Structure
REQ-032 SHALL place the FSM state encoding (IDLE=0, REQ=1, SEND=2, GAP=3) and ICMP type constants (echo request 8, reply 0) in shared package icmp_pkg.
REQ-033 SHALL implement the FIFO as sub-module icmp_seq_fifo (synchronous, first-word-fall-through, 16-bit, depth P_FIFO_DEPTH).

Verification
REQ-034 Single trigger seq=16'h0001 -> o_icmp_req high 2 cycles later with o_icmp_seq=16'h0001; grant then done -> idle, o_pending=0.
REQ-035 5 triggers (seq 1..5) back-to-back with grant held low, depth 4 -> o_pending=4, o_drop_cnt=1; replies emitted in order 1,2,3,4.
REQ-036 Full FIFO, trigger in the same cycle as grant -> push accepted, o_drop_cnt unchanged, o_pending stays 4.
REQ-037 Grant with no done for 4096 cycles -> return to IDLE, o_drop_cnt+1, next queued seq requested.
REQ-038 With ICMP_RATE_LIMIT_EN and P_RATE_GAP=16, two queued triggers -> second o_icmp_req rises no earlier than 17 cycles after the first done.
REQ-039 Assert i_rst_n=0 in SEND -> all outputs 0 asynchronously; after release, a new trigger is served normally.
